// File: rtl/shift_load_reg_if.sv
// Bundles the control, data and status signals of shift_load_reg.
//   master : drives sclr, en, mode, d, sin; observes q, sout, cnt, done
//   slave  : the register itself; consumes the controls, drives the status
// N must match the N of the shift_load_reg instance bound to this interface.
interface shift_load_reg_if #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
);
  logic             sclr;
  logic             en;
  logic [1:0]       mode;
  logic [N-1:0]     d;
  logic             sin;
  logic [N-1:0]     q;
  logic             sout;
  logic [CNT_W-1:0] cnt;
  logic             done;

  modport master (
    output sclr, en, mode, d, sin,
    input  q, sout, cnt, done
  );

  modport slave (
    input  sclr, en, mode, d, sin,
    output q, sout, cnt, done
  );
endinterface

// File: rtl/shift_load_reg.sv
// N-bit multi-mode register (hold / parallel load / shift right / shift left)
// with a saturating shift counter and done flag. Used as the product/multiplier
// register of a shift-add sequential multiplier.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   clr_n      : asynchronous active-low clear of all state
//   bus.sclr   : synchronous clear, wins over en and mode
//   bus.en     : operation enable, 0 holds everything
//   bus.mode   : 00 hold, 01 load, 10 shift right, 11 shift left
//   bus.d      : parallel load data
//   bus.sin    : serial input bit shifted in
//   bus.q      : register contents
//   bus.sout   : last bit shifted out
//   bus.cnt    : shifts since last load/clear, saturating at N
//   bus.done   : high once cnt has reached N
module shift_load_reg #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  shift_load_reg_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  logic [N-1:0]     q_q, q_d;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_s;

  // Next-state selection: sclr, then enable, then the mode decode.
  always_comb begin
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    shift_s = 1'b0;
    if (bus.sclr) begin
      q_d    = '0;
      sout_d = 1'b0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!bus.en) begin
      q_d = q_q;
    end else begin
      case (bus.mode)
        2'b00: begin
          q_d = q_q;
        end
        2'b01: begin
          q_d    = bus.d;
          cnt_d  = '0;
          done_d = 1'b0;
        end
        2'b10: begin
          q_d     = {bus.sin, q_q[N-1:1]};
          sout_d  = q_q[0];
          shift_s = 1'b1;
        end
        2'b11: begin
          q_d     = {q_q[N-2:0], bus.sin};
          sout_d  = q_q[N-1];
          shift_s = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end

    // Direction-agnostic counting; saturates so done never falls on extra shifts.
    if (shift_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      done_d = (cnt_d == CNT_MAX);
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State flops with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;

endmodule
